// File: rtl/apb_completer_regfile_pkg.sv
// Shared types and defaults for the APB register-file completer.
// Holds the FSM state enum, bus width defaults and word-index helper.
package apb_completer_regfile_pkg;

  localparam int          ADDR_W_D   = 8;
  localparam int          DATA_W_D   = 32;
  localparam int          DEPTH_D    = 16;
  localparam int          IDX_W      = 4;
  localparam logic [31:0] ID_VALUE_D = 32'hA5B0_0001;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Word index from the locally decoded byte address.
  function automatic logic [IDX_W-1:0] word_idx(
    input logic [5:0] a
  );
    return a[5:2];
  endfunction

endpackage

// File: rtl/apb_completer_regfile_if.sv
// APB3 completer-side bus bundle.
// master drives psel/penable/pwrite/paddr/pwdata; slave answers.
interface apb_completer_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB3 completer over a 16x32 register file with wait states/PSLVERR.
// Ports: clk, rst (async active-low), bus (APB slave modport).
module apb_completer_regfile
  import apb_completer_regfile_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_D,
  parameter int          DATA_W      = DATA_W_D,
  parameter int          DEPTH       = DEPTH_D,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_D
) (
  input logic                     clk,
  input logic                     rst,
  apb_completer_regfile_if.slave  bus
);

  localparam logic [3:0] WAIT_L =
    4'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0] ID_IDX =
    IDX_W'(DEPTH - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [5:0]          r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_regs [DEPTH-1];

  logic [IDX_W-1:0]    w_idx;
  logic                w_ready;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  // Upper address bits belong to the decoder; psel does selection.
  assign w_unused = ^bus.paddr[ADDR_W-1:6];

  assign w_idx   = word_idx(r_addr);
  assign w_ready = (r_state == ACCESS)
                && (r_cnt == 4'd0);

  // Misaligned access, or write to the read-only ID word.
  assign w_err = (r_addr[1:0] != 2'b00)
              || (r_write && (w_idx == ID_IDX));

  always_comb begin
    w_rdata = '0;
    if (w_ready && !r_write && !w_err) begin
      if (w_idx == ID_IDX)
        w_rdata = DATA_W'(ID_VALUE);
      else
        w_rdata = r_regs[w_idx];
    end
  end

  assign bus.pready  = w_ready;
  assign bus.pslverr = w_ready && w_err;
  assign bus.prdata  = w_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      for (int i = 0; i < DEPTH - 1; i++)
        r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Only a true setup phase starts a transfer.
          if (bus.psel && !bus.penable) begin
            r_addr  <= bus.paddr[5:0];
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            r_cnt   <= WAIT_L;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            r_state <= IDLE;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (bus.penable) begin
            if (r_write && !w_err)
              r_regs[w_idx] <= r_wdata;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- APB3 completer (slave) that sits behind one select line of the existing 4-way APB requester/decoder (paddr[7:6] picks the slave).
- It terminates transfers into a 16-word × 32-bit register file, with programmable wait states and PSLVERR signalling.
- It is the responding end for the addr_out/data_out/wr_out bundles that the decoder drives today.

Parameters:
- ADDR_W, 8, APB address width (full paddr; only [5:0] decoded locally)
- DATA_W, 32, APB data width
- DEPTH, 16, number of 32-bit registers; word index = paddr[5:2]
- WAIT_CYCLES, 1, wait states inserted per transfer (0..15)
- ID_VALUE, 32'hA5B0_0001, constant returned by read-only word DEPTH-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- psel  in  1  completer select from the decoder
- penable  in  1  APB access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data, valid only when pready=1 on a read
- pready  out  1  transfer completion
- pslverr  out  1  error response, valid only when pready=1

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, wait counter 0, regs[0..DEPTH-2] = 0, prdata = 0, pready = 0, pslverr = 0. Assertion mid-transfer aborts it with no write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel=1 and penable=0 (setup phase): latch paddr, pwrite, pwdata; load cnt = WAIT_CYCLES; go to ACCESS.
  - penable=1 without a preceding setup: ignored, stay in IDLE.
- ACCESS:
  - pready = (cnt==0), combinational from registered state.
  - While cnt != 0: cnt decrements each clock; prdata = 0; pslverr = 0.
  - Cycle where psel & penable & pready: transfer completes, FSM returns to IDLE.
  - psel=0 while in ACCESS: abort to IDLE, no register update.
- Latency: setup cycle + (WAIT_CYCLES + 1) access cycles. With WAIT_CYCLES=0 a transfer is 2 clocks.
- Back-to-back transfers: the next setup phase is sampled in IDLE on the clock after completion. Every transfer requires its own setup phase.
- Error (pslverr=1 with pready):
  - paddr[1:0] != 0 (misaligned), or
  - a write to word DEPTH-1 (read-only ID).
  - An errored write does not modify any register. An errored read returns prdata = 0.
- Write commit: regs[idx] <= latched pwdata on the completing clock edge. The new value is visible to the next read.
- Read: prdata = regs[idx] (or ID_VALUE for word DEPTH-1) during the completing cycle, 0 otherwise.
- paddr[7:6] are ignored; selection is by psel only.
- The latched address and data are used for the whole transfer. Changes on paddr/pwdata during ACCESS have no effect.

Decomposition:
- apb_pkg: ADDR_W/DATA_W defaults, state enum {IDLE, ACCESS}, ID_VALUE constant, index-extraction function.
- Single module. The wait counter and register array stay inline; no sub-module is warranted.

Test Plan:
- Reset then WAIT_CYCLES=1: write 0x00 ← 32'hFFFF_FFFF (psel=1,pwrite=1), then read 0x00 -> pready low 1 access cycle, then high; read returns 32'hFFFF_FFFF, pslverr=0.
- WAIT_CYCLES=0: write 0x04 ← 32'h1234_5678, then immediately read 0x04 -> each transfer completes in exactly 2 clocks; prdata=32'h1234_5678.
- Read 0x3C -> prdata=32'hA5B0_0001. Write 0x3C ← 0 -> pslverr=1 with pready; a subsequent read still returns 32'hA5B0_0001.
- Write 0x0E (misaligned) ← 32'hDEAD_BEEF -> pslverr=1; reads of 0x0C and 0x0E... read 0x0C returns prior value 0.
- WAIT_CYCLES=3: start write 0x08 ← 32'h5555_AAAA, drop rst after the 2nd wait cycle -> outputs 0 immediately; after release, read 0x08 returns 0.
- penable=1 with psel=1 but no setup cycle, paddr=0x10 -> pready stays 0, no register change. A following proper write to 0x10 completes normally.
